// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_ctr.sv
// Frame-sync tracker and slot counter for the TDM demux.
// Framing-error strobe is only built with TDM_FRAME_ERR_EN.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  valid_i,
    input  logic  sync_i,
    output slot_t slot_o,
    output logic  wr_c_o,
    output slot_t wr_idx_c_o,
`ifdef TDM_FRAME_ERR_EN
    output logic  err_c_o,
`endif
    output logic  done_c_o
);

    state_e state_q, state_d;
    slot_t  slot_q,  slot_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // A sync word always (re)starts a frame, whatever the current slot.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_c_o     = 1'b0;
        wr_idx_c_o = '0;
        done_c_o   = 1'b0;
        if (valid_i) begin
            case (state_q)
                IDLE: begin
                    if (sync_i) begin
                        wr_c_o  = 1'b1;
                        slot_d  = slot_t'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    if (sync_i) begin
                        wr_c_o = 1'b1;
                        slot_d = slot_t'(1);
                    end else if (slot_q == '0) begin
                        state_d = IDLE;
                    end else if (slot_q == LAST_SLOT) begin
                        done_c_o = 1'b1;
                        slot_d   = '0;
                    end else begin
                        wr_c_o     = 1'b1;
                        wr_idx_c_o = slot_q;
                        slot_d     = slot_q + slot_t'(1);
                    end
                end
            endcase
        end
    end

`ifdef TDM_FRAME_ERR_EN
    // Early sync mid-frame, or a missing sync at a frame boundary.
    assign err_c_o = valid_i && (state_q == RECV) &&
                     (sync_i ? (slot_q != '0) : (slot_q == '0));
`endif

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM receiver: shadows slots 0..2 and commits whole frames to ch0..ch3.
// Optional framing-error pulse enabled by TDM_FRAME_ERR_EN.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             frame_err
);

    logic  wr_c;
    slot_t wr_idx_c;
    logic  done_c;
    slot_t slot_s;

    logic [NUM_SLOTS-2:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] ch_q,     ch_d;
    logic                            out_valid_q;

`ifdef TDM_FRAME_ERR_EN
    logic err_c;
    logic frame_err_q;
`endif

    tdm_slot_ctr u_ctr (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (in_valid),
        .sync_i     (in_sync),
        .slot_o     (slot_s),
        .wr_c_o     (wr_c),
        .wr_idx_c_o (wr_idx_c),
`ifdef TDM_FRAME_ERR_EN
        .err_c_o    (err_c),
`endif
        .done_c_o   (done_c)
    );

    // Slot 3 bypasses the shadow so the whole frame lands on one edge.
    always_comb begin
        shadow_d = shadow_q;
        ch_d     = ch_q;
        for (int i = 0; i < int'(NUM_SLOTS) - 1; i++) begin
            if (wr_c && (wr_idx_c == slot_t'(i))) begin
                shadow_d[i] = in_data;
            end
        end
        if (done_c) begin
            ch_d[0] = shadow_q[0];
            ch_d[1] = shadow_q[1];
            ch_d[2] = shadow_q[2];
            ch_d[3] = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q    <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            ch_q        <= ch_d;
            out_valid_q <= done_c;
        end
    end

`ifdef TDM_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_c;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign ch0       = ch_q[0];
    assign ch1       = ch_q[1];
    assign ch2       = ch_q[2];
    assign ch3       = ch_q[3];
    assign out_valid = out_valid_q;
    assign slot      = slot_s;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed vector table, hand sequences,
// and random traffic against a queue-based frame model.
module tb_tdm_demux4;

    localparam int unsigned W = 32;

`ifdef TDM_FRAME_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sync;
    logic [W-1:0] in_data;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         out_valid;
    logic [1:0]   slot;
    logic         frame_err;

    int n_checks = 0;
    int n_err    = 0;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_data   (in_data),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .out_valid (out_valid),
        .slot      (slot),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Frame model: a frame is the queue of words collected since the last sync.
    bit           m_synced;
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_ch[4];
    bit           m_ov;
    bit           m_fe;

    function automatic void model_reset();
        m_synced = 1'b0;
        m_q.delete();
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_ov = 1'b0;
        m_fe = 1'b0;
    endfunction

    function automatic void model_step(bit v, bit s, logic [W-1:0] d);
        m_ov = 1'b0;
        m_fe = 1'b0;
        if (!v) return;
        if (s) begin
            if (m_synced && m_q.size() != 0) m_fe = 1'b1;
            m_q.delete();
            m_q.push_back(d);
            m_synced = 1'b1;
        end else if (m_synced) begin
            if (m_q.size() == 0) begin
                m_synced = 1'b0;
                m_fe     = 1'b1;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
                    m_ov = 1'b1;
                    m_q.delete();
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_ch0", ch0, m_ch[0]);
        chk("m_ch1", ch1, m_ch[1]);
        chk("m_ch2", ch2, m_ch[2]);
        chk("m_ch3", ch3, m_ch[3]);
        chk("m_out_valid", W'(out_valid), W'(m_ov));
        chk("m_slot", W'(slot), W'(m_q.size()));
        chk("m_frame_err", W'(frame_err), W'(m_fe & FE_EN));
    endtask

    // One clock with the given inputs; returns after sampling outputs.
    task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit           v;
        bit           s;
        logic [W-1:0] d;
        bit           ov;
        logic [1:0]   sl;
        bit           fe;
        logic [W-1:0] c0, c1, c2, c3;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit v, bit s, logic [W-1:0] d, bit ov, logic [1:0] sl, bit fe,
                                logic [W-1:0] c0, logic [W-1:0] c1, logic [W-1:0] c2, logic [W-1:0] c3);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ov = ov; r.sl = sl; r.fe = fe;
        r.c0 = c0; r.c1 = c1; r.c2 = c2; r.c3 = c3;
        return r;
    endfunction

    initial begin
        int ov_cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;

        // Unsynchronised words, then frame A, then early-sync frame, then frame B + missing sync.
        vecs.push_back(mk(1, 0, 32'h11, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h12, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 32'hA0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hA1, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hA2, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'hA3, 1, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(0, 0, 32'hFF, 0, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 1, 32'h5,  0, 1, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 0, 32'h6,  0, 2, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 0, 32'h7,  0, 3, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 1, 32'h9,  0, 1, 1, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 0, 32'h1,  0, 2, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 0, 32'h2,  0, 3, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
        vecs.push_back(mk(1, 0, 32'h3,  1, 0, 0, 32'h9,  32'h1,  32'h2,  32'h3));
        vecs.push_back(mk(1, 1, 32'hB0, 0, 1, 0, 32'h9,  32'h1,  32'h2,  32'h3));
        vecs.push_back(mk(1, 0, 32'hB1, 0, 2, 0, 32'h9,  32'h1,  32'h2,  32'h3));
        vecs.push_back(mk(1, 0, 32'hB2, 0, 3, 0, 32'h9,  32'h1,  32'h2,  32'h3));
        vecs.push_back(mk(1, 0, 32'hB3, 1, 0, 0, 32'hB0, 32'hB1, 32'hB2, 32'hB3));
        vecs.push_back(mk(1, 0, 32'h55, 0, 0, 1, 32'hB0, 32'hB1, 32'hB2, 32'hB3));
        vecs.push_back(mk(1, 0, 32'h66, 0, 0, 0, 32'hB0, 32'hB1, 32'hB2, 32'hB3));

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d);
            chk($sformatf("vec%0d_ch0", i), ch0, vecs[i].c0);
            chk($sformatf("vec%0d_ch1", i), ch1, vecs[i].c1);
            chk($sformatf("vec%0d_ch2", i), ch2, vecs[i].c2);
            chk($sformatf("vec%0d_ch3", i), ch3, vecs[i].c3);
            chk($sformatf("vec%0d_out_valid", i), W'(out_valid), W'(vecs[i].ov));
            chk($sformatf("vec%0d_slot", i), W'(slot), W'(vecs[i].sl));
            chk($sformatf("vec%0d_frame_err", i), W'(frame_err), W'(vecs[i].fe & FE_EN));
        end

        // Frame C with two idle cycles between words: one pulse, same result.
        ov_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, W'(32'hC0 + i));
            chk_model();
            ov_cnt += int'(out_valid);
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, 1'b0, 32'hDEAD);
                chk_model();
                ov_cnt += int'(out_valid);
            end
        end
        chk("gap_pulses", W'(ov_cnt), W'(1));
        chk("gap_ch3", ch3, 32'hC3);

        // Reset mid-frame, then C2/C3 must be ignored until a fresh sync.
        drive(1'b1, 1'b1, 32'hC0);
        drive(1'b1, 1'b0, 32'hC1);
        chk_model();
        do_reset();
        chk("rst_ch0", ch0, 32'h0);
        drive(1'b1, 1'b0, 32'hC2);
        chk_model();
        drive(1'b1, 1'b0, 32'hC3);
        chk_model();
        chk("rst_ignore_slot", W'(slot), W'(0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, W'(32'hE0 + i));
            chk_model();
        end
        chk("post_rst_ch0", ch0, 32'hE0);

        // Random traffic against the frame model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom % 4) != 0, ($urandom % 5) == 0, W'($urandom));
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the channel data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data and in_sync are valid this cycle.
REQ-005 The block SHALL have port in_sync, input, 1 bit: qualified by in_valid; marks the word as slot 0 of a frame.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the time-multiplexed word.
REQ-007 The block SHALL have ports ch0, ch1, ch2 and ch3, each output, WIDTH bits: the demultiplexed channel registers.
REQ-008 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking that ch0..ch3 were updated with a complete frame.
REQ-009 The block SHALL have port slot, output, 2 bits: the slot index expected for the next accepted word.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle framing-error pulse (see Configuration).

Function
REQ-011 The block SHALL be the receive end of a 4-slot TDM link: a frame is 4 valid words, slot 0 to slot 3, and slot 0 is flagged by in_sync.
REQ-012 The block SHALL implement a state machine with states IDLE (unsynchronised) and RECV (synchronised).
REQ-013 In IDLE, in_valid with in_sync SHALL store in_data into shadow[0], set slot=1 and move to RECV; in_valid without in_sync SHALL drop the word.
REQ-014 In RECV with slot=1 or slot=2, in_valid without in_sync SHALL store in_data into shadow[slot] and increment slot.
REQ-015 In RECV with slot=3, in_valid without in_sync SHALL load ch0..ch2 from shadow[0..2] and ch3 from in_data on the same edge, assert out_valid for exactly that following cycle, and set slot=0.
REQ-016 Latency SHALL be 1 cycle from the slot-3 input to the ch update plus the out_valid pulse; back-to-back frames SHALL be accepted with no idle cycles.
REQ-017 In RECV with slot=0, in_valid with in_sync SHALL start a new frame (shadow[0], slot=1).
REQ-018 In RECV with slot=0, in_valid without in_sync SHALL drop the word and return to IDLE.
REQ-019 In RECV with slot 1..3, in_valid with in_sync (early sync) SHALL abandon the partial frame, store in_data into shadow[0] and set slot=1, leaving ch0..ch3 unchanged and out_valid low.
REQ-020 Cycles with in_valid low SHALL change no state; a frame MAY be spread over any number of cycles.
REQ-021 ch0..ch3 SHALL hold their value between complete frames and SHALL never be partially updated.

Reset
REQ-022 When rst is asserted, the block SHALL asynchronously set the state to IDLE, slot=0, out_valid=0, frame_err=0, ch0..ch3=0 and shadow[0..2]=0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL ignore words until the next in_sync.

Configuration
REQ-024 Macro TDM_FRAME_ERR_EN SHALL select framing-error detection.
REQ-025 With TDM_FRAME_ERR_EN defined, frame_err SHALL pulse for one cycle (registered) on the events of REQ-018 and REQ-019.
REQ-026 Without TDM_FRAME_ERR_EN, frame_err SHALL be tied to 0, no detection logic SHALL be built, and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package tdm_pkg SHALL hold: the constant NUM_SLOTS=4, the 2-bit slot typedef, and the state enum {IDLE, RECV}.
REQ-028 The slot counter with its sync and restart logic SHALL be a sub-module named tdm_slot_ctr; the data path and output registers SHALL live in tdm_demux4.

Verification
REQ-029 The bench SHALL check: reset, then words A0(sync), A1, A2, A3 on consecutive cycles -> one cycle after A3, ch0..3=A0..A3 and out_valid=1 for one cycle.
REQ-030 The bench SHALL check: 3 words without sync after reset -> no ch change, out_valid=0, slot=0.
REQ-031 The bench SHALL check: 5, 6, 7 (sync on 5), then 9 with in_sync, then 1, 2, 3 -> ch0..3=9,1,2,3, previous ch values kept until then, frame_err pulse only with TDM_FRAME_ERR_EN.
REQ-032 The bench SHALL check: complete frame B, then a non-sync word at slot 0 -> return to IDLE, ch keeps B, frame_err pulse only with the macro.
REQ-033 The bench SHALL check: frame C with in_valid low for 2 cycles between each word -> same result as contiguous, one out_valid pulse.
REQ-034 The bench SHALL check: rst asserted after C1 mid-frame -> all outputs 0 immediately; following C2, C3 ignored until a sync word.
